// File: rtl/aes_inv_linear_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_inv_linear_round: registered InvShiftRows + AddRoundKey +            |
// | InvMixColumns (bypassed on the last round), 1-cycle latency.  Rev 1.0    |
// +--------------------------------------------------------------------------+
module aes_inv_linear_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] in_state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic         out_valid,
  output logic [127:0] out_state
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers 09/0B/0D/0E are sums of the x2/x4/x8 chain terms.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      x2[i] = xtime(b[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ b[i];
      mb[i] = x8[i] ^ x2[i] ^ b[i];
      md[i] = x8[i] ^ x4[i] ^ b[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] w_shifted;
  logic [127:0] w_added;
  logic [127:0] w_mixed;
  logic [127:0] w_result;

  logic         out_valid_d, out_valid_q;
  logic [127:0] out_state_d, out_state_q;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
        // Row r rotates right by r: destination column c takes source column (c-r) mod 4.
        assign w_shifted[127-8*(4*c+r) -: 8] = in_state[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
      assign w_mixed[127-32*c -: 32] = inv_mix_col(w_added[127-32*c -: 32]);
    end
  endgenerate

  assign w_added  = w_shifted ^ round_key;
  assign w_result = last ? w_added : w_mixed;

  always_comb begin
    out_valid_d = in_valid;
    out_state_d = out_state_q;
    if (in_valid) begin
      out_state_d = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= 128'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_linear_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes_inv_linear_round: scoreboard bench for aes_inv_linear_round.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_aes_inv_linear_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = 128'h0;
  logic [127:0] round_key = 128'h0;
  logic         last = 1'b0;
  logic         out_valid;
  logic [127:0] out_state;

  aes_inv_linear_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_state  (in_state),
    .round_key (round_key),
    .last      (last),
    .out_valid (out_valid),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q [$];
  logic [127:0] held_exp = 128'h0;

  logic [7:0]  sbox  [0:255];
  logic [7:0]  isbox [0:255];
  logic [31:0] w     [0:43];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic l);
    logic [7:0] st [4][4];
    logic [7:0] t  [4][4];
    logic [7:0] m  [4][4];
    logic [7:0] co [4][4];
    logic [127:0] res;
    co[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    co[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
    co[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
    co[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r][c] = st[r][(c - r + 4) % 4] ^ k[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[r][c] = 8'h00;
        for (int j = 0; j < 4; j++) m[r][c] ^= gmul(co[r][j], t[j][c]);
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = l ? t[r][c] : m[r][c];
    return res;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] rk(input int i);
    return {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {127'h0, out_valid}, 128'h0);
        end else begin
          held_exp = exp_q.pop_front();
          check("out_state", out_state, held_exp);
        end
      end else begin
        if (exp_q.size() != 0) begin
          check("missing_out_valid", {127'h0, out_valid}, 128'h1);
          void'(exp_q.pop_front());
        end else begin
          check("out_state_hold", out_state, held_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      input logic [127:0] e);
    in_valid  = 1'b1;
    in_state  = s;
    round_key = k;
    last      = l;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [127:0] s, k, e, sub;
    logic [7:0]   inv, p;
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic         l;

    // S-box tables from GF inverse plus affine map
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        p = 8'h01;
        repeat (254) p = gmul(p, 8'(x));
        inv = p;
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    k = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^
              {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {127'h0, out_valid}, 128'h0);
    check("reset_state", out_state, 128'h0);
    rst_n = 1'b1;
    idle(1);

    // 2: InvShiftRows only
    send(128'h00112233445566778899aabbccddeeff, 128'h0, 1'b1,
         128'h00ddaa774411eebb885522ffcc996633);
    // 3: InvMixColumns
    send({4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'hdb135345}});
    send({4{32'h9fdc589d}}, 128'h0, 1'b0, {4{32'hf20a225c}});
    send({4{32'h01010101}}, 128'h0, 1'b0, {4{32'h01010101}});
    // 4: AddRoundKey
    k = 128'h000102030405060708090a0b0c0d0e0f;
    send(128'h0, k, 1'b1, k);
    send(128'h0, k, 1'b0, model_round(128'h0, k, 1'b0));
    idle(2);

    // 5: streaming with last toggling, then a gap
    l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send(s, k, l, model_round(s, k, l));
      l = ~l;
    end
    idle(3);
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send(s, k, 1'b0, model_round(s, k, 1'b0));
    idle(2);

    // 1 (mid-stream): asynchronous reset discards the in-flight result
    send(128'h0123456789abcdeffedcba9876543210, 128'h0, 1'b0,
         model_round(128'h0123456789abcdeffedcba9876543210, 128'h0, 1'b0));
    send(128'hffeeddccbbaa99887766554433221100, 128'h1, 1'b1,
         model_round(128'hffeeddccbbaa99887766554433221100, 128'h1, 1'b1));
    rst_n = 1'b0;
    #1;
    check("midreset_valid", {127'h0, out_valid}, 128'h0);
    check("midreset_state", out_state, 128'h0);
    exp_q.delete();
    held_exp = 128'h0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 6: FIPS-197 App. C.1 inverse cipher
    s = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ rk(10);
    for (int r = 1; r <= 10; r++) begin
      sub = inv_sub(s);
      if (r == 10) e = 128'h00112233445566778899aabbccddeeff;
      else         e = model_round(sub, rk(10 - r), 1'b0);
      send(sub, rk(10 - r), (r == 10), e);
      s = e;
    end
    idle(1);

    // drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
